// File: rtl/my_adder_result_display.sv
// Snapshot viewer and checker for the board's 2-bit full adder.
// A debounced LOAD press captures A, B, CIN and {COUT,S}. It also checks the
// captured sum against a golden A+B+CIN. The snapshot is scanned across a
// 4-digit multiplexed seven-segment display.
//
// Ports:
//   CLOCK    : system clock, rising edge
//   RESETN   : asynchronous active-low reset
//   A, B     : adder operands (2 bit)
//   CIN      : adder carry-in
//   S, COUT  : adder result under test
//   LOAD     : raw, bouncy, asynchronous push-button
//   AN       : digit anodes, active-low, AN[0] = rightmost
//   SEG      : segments g..a, active-low
//   DP       : decimal point, active-low; marks a checker error on digit 0
//   CAPTURED : a snapshot has been taken since reset
//   ERR      : captured result differs from A+B+CIN
module my_adder_result_display #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REFRESH_BITS    = 18
) (
  input  logic       CLOCK,
  input  logic       RESETN,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       CIN,
  input  logic [1:0] S,
  input  logic       COUT,
  input  logic       LOAD,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       CAPTURED,
  output logic       ERR
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                    ld_meta_q, ld_sync_q;
  logic [CNT_W-1:0]        db_cnt_q, db_cnt_d;
  logic                    ld_db_q, ld_db_d;
  logic                    ld_db_dly_q;
  logic                    press_c;
  logic [REFRESH_BITS-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]              sel_c;
  logic [2:0]              digit_c;
  logic [1:0]              snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic                    snap_cin_q, snap_cin_d;
  logic [2:0]              snap_sum_q, snap_sum_d;
  logic                    captured_q, captured_d;
  logic                    err_q, err_d;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  // Active-low gfedcba pattern for the values 0..7.
  function automatic logic [6:0] seg_decode(input logic [2:0] v);
    case (v)
      3'd0:    seg_decode = 7'b1000000;
      3'd1:    seg_decode = 7'b1111001;
      3'd2:    seg_decode = 7'b0100100;
      3'd3:    seg_decode = 7'b0110000;
      3'd4:    seg_decode = 7'b0011001;
      3'd5:    seg_decode = 7'b0010010;
      3'd6:    seg_decode = 7'b0000010;
      default: seg_decode = 7'b1111000;
    endcase
  endfunction

  assign press_c = ld_db_q & ~ld_db_dly_q;
  assign sel_c   = ref_cnt_q[REFRESH_BITS-1 -: 2];

  // Digit value selected by the scan position.
  always_comb begin
    digit_c = snap_sum_q;
    case (sel_c)
      2'd0:    digit_c = snap_sum_q;
      2'd1:    digit_c = {2'b00, snap_cin_q};
      2'd2:    digit_c = {1'b0, snap_b_q};
      default: digit_c = {1'b0, snap_a_q};
    endcase
  end

  // Next-state logic: debouncer, capture/check, refresh counter, display.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    ld_db_d    = ld_db_q;
    ref_cnt_d  = ref_cnt_q + REFRESH_BITS'(1);
    snap_a_d   = snap_a_q;
    snap_b_d   = snap_b_q;
    snap_cin_d = snap_cin_q;
    snap_sum_d = snap_sum_q;
    captured_d = captured_q;
    err_d      = err_q;
    an_d       = 4'b1111;
    seg_d      = 7'b1111111;
    dp_d       = 1'b1;

    // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    if (ld_sync_q == ld_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == CNT_LAST) begin
      ld_db_d  = ~ld_db_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + CNT_W'(1);
    end

    if (press_c) begin
      snap_a_d   = A;
      snap_b_d   = B;
      snap_cin_d = CIN;
      snap_sum_d = {COUT, S};
      captured_d = 1'b1;
      err_d      = ({COUT, S} != (3'(A) + 3'(B) + 3'(CIN)));
    end

    // Anode and segments come from one register stage so they switch together.
    if (captured_q) begin
      an_d  = ~(4'b0001 << sel_c);
      seg_d = seg_decode(digit_c);
      dp_d  = ~((sel_c == 2'd0) && err_q);
    end
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      ld_meta_q   <= 1'b0;
      ld_sync_q   <= 1'b0;
      db_cnt_q    <= '0;
      ld_db_q     <= 1'b0;
      ld_db_dly_q <= 1'b0;
      ref_cnt_q   <= '0;
      snap_a_q    <= '0;
      snap_b_q    <= '0;
      snap_cin_q  <= 1'b0;
      snap_sum_q  <= '0;
      captured_q  <= 1'b0;
      err_q       <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
    end else begin
      ld_meta_q   <= LOAD;
      ld_sync_q   <= ld_meta_q;
      db_cnt_q    <= db_cnt_d;
      ld_db_q     <= ld_db_d;
      ld_db_dly_q <= ld_db_q;
      ref_cnt_q   <= ref_cnt_d;
      snap_a_q    <= snap_a_d;
      snap_b_q    <= snap_b_d;
      snap_cin_q  <= snap_cin_d;
      snap_sum_q  <= snap_sum_d;
      captured_q  <= captured_d;
      err_q       <= err_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign AN       = an_q;
  assign SEG      = seg_q;
  assign DP       = dp_q;
  assign CAPTURED = captured_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_my_adder_result_display.sv
// Self-checking bench for my_adder_result_display with short debounce and
// refresh settings. Expected snapshots are queued when a press is driven and
// checked against a full display scan.
module tb_my_adder_result_display;

  localparam int unsigned DEB = 4;
  localparam int unsigned RB  = 4;
  localparam int unsigned SCAN_CYCLES = 1 << RB;

  logic       CLOCK, RESETN;
  logic [1:0] A, B, S;
  logic       CIN, COUT, LOAD;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP, CAPTURED, ERR;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       cin;
    logic [2:0] sum;
    logic       err;
  } snap_t;

  snap_t sb_q[$];
  int    n_checks = 0;
  int    n_errs   = 0;

  my_adder_result_display #(.DEBOUNCE_CYCLES(DEB), .REFRESH_BITS(RB)) dut (
    .CLOCK(CLOCK), .RESETN(RESETN), .A(A), .B(B), .CIN(CIN), .S(S), .COUT(COUT),
    .LOAD(LOAD), .AN(AN), .SEG(SEG), .DP(DP), .CAPTURED(CAPTURED), .ERR(ERR)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [2:0] v);
    case (v)
      3'd0:    seg_of = 7'b1000000;
      3'd1:    seg_of = 7'b1111001;
      3'd2:    seg_of = 7'b0100100;
      3'd3:    seg_of = 7'b0110000;
      3'd4:    seg_of = 7'b0011001;
      3'd5:    seg_of = 7'b0010010;
      3'd6:    seg_of = 7'b0000010;
      default: seg_of = 7'b1111000;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic set_in(input logic [1:0] a, input logic [1:0] b, input logic cin,
                        input logic [1:0] s, input logic cout);
    A = a; B = b; CIN = cin; S = s; COUT = cout;
  endtask

  // Golden snapshot from the inputs currently applied.
  task automatic push_expected();
    snap_t e;
    logic [2:0] golden;
    golden = 3'(A) + 3'(B) + 3'(CIN);
    e.a = A; e.b = B; e.cin = CIN; e.sum = {COUT, S};
    e.err = ({COUT, S} != golden);
    sb_q.push_back(e);
  endtask

  task automatic do_press(input int hold, input int rest);
    push_expected();
    LOAD = 1'b1;
    step(hold);
    LOAD = 1'b0;
    step(rest);
  endtask

  task automatic check_blank(input string tag);
    repeat (SCAN_CYCLES) begin
      @(negedge CLOCK);
      check_eq({tag, "_an"}, 32'(AN), 32'h0000000F);
      check_eq({tag, "_seg"}, 32'(SEG), 32'h0000007F);
      check_eq({tag, "_dp"}, 32'(DP), 32'd1);
    end
  endtask

  // Pop the oldest expected snapshot and compare it against one full scan.
  task automatic check_scan(input string tag);
    snap_t      e;
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];
    logic [3:0] seen;
    int         d;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    exp_seg[0] = seg_of(e.sum);
    exp_seg[1] = seg_of({2'b00, e.cin});
    exp_seg[2] = seg_of({1'b0, e.b});
    exp_seg[3] = seg_of({1'b0, e.a});
    exp_dp[0]  = ~e.err;
    exp_dp[1]  = 1'b1;
    exp_dp[2]  = 1'b1;
    exp_dp[3]  = 1'b1;
    seen = 4'b0000;
    @(negedge CLOCK);
    check_eq({tag, "_captured"}, 32'(CAPTURED), 32'd1);
    check_eq({tag, "_err"}, 32'(ERR), 32'(e.err));
    repeat (SCAN_CYCLES) begin
      @(negedge CLOCK);
      case (AN)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      if (d < 0) begin
        check_eq({tag, "_an_onehot"}, 32'(AN), 32'h0000000E);
      end else begin
        seen[d] = 1'b1;
        check_eq($sformatf("%s_seg_d%0d", tag, d), 32'(SEG), 32'(exp_seg[d]));
        check_eq($sformatf("%s_dp_d%0d", tag, d), 32'(DP), 32'(exp_dp[d]));
      end
    end
    check_eq({tag, "_all_digits"}, 32'(seen), 32'h0000000F);
  endtask

  initial begin
    RESETN = 1'b1;
    LOAD   = 1'b0;
    set_in(2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    #2 RESETN = 1'b0;
    #1;
    check_eq("rst_an", 32'(AN), 32'h0000000F);
    check_eq("rst_seg", 32'(SEG), 32'h0000007F);
    check_eq("rst_dp", 32'(DP), 32'd1);
    check_eq("rst_captured", 32'(CAPTURED), 32'd0);
    check_eq("rst_err", 32'(ERR), 32'd0);
    step(3);
    RESETN = 1'b1;
    step(1);
    check_blank("pre_capture");

    // Bounce: 3 high, 1 low, 2 high never sustains DEB disagreeing cycles.
    LOAD = 1'b1; step(3);
    LOAD = 1'b0; step(1);
    LOAD = 1'b1; step(2);
    LOAD = 1'b0; step(8);
    check_eq("bounce_captured", 32'(CAPTURED), 32'd0);
    check_eq("bounce_cnt", 32'(dut.db_cnt_q), 32'd0);
    check_blank("bounce");

    // Basic capture with latency: CAPTURED rises on edge DEB+3.
    set_in(2'b01, 2'b01, 1'b1, 2'b11, 1'b0);
    push_expected();
    LOAD = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check_eq($sformatf("lat_edge%0d", k), 32'(CAPTURED), 32'(k >= int'(DEB + 3)));
    end
    LOAD = 1'b0;
    step(10);
    check_scan("basic");

    // Checker error: 2+3+1 = 6 but the adder reports 1.
    set_in(2'b10, 2'b11, 1'b1, 2'b01, 1'b0);
    do_press(10, 10);
    check_scan("error");

    // Hold: changing A while LOAD stays high must not recapture.
    set_in(2'b01, 2'b10, 1'b0, 2'b11, 1'b0);
    push_expected();
    LOAD = 1'b1;
    step(10);
    A = 2'b11;
    step(5);
    check_scan("hold");
    LOAD = 1'b0;
    step(10);

    // Re-press captures A=3 once; a later change while held is ignored.
    set_in(2'b11, 2'b10, 1'b0, 2'b01, 1'b1);
    push_expected();
    LOAD = 1'b1;
    step(10);
    S = 2'b11;
    step(20);
    LOAD = 1'b0;
    step(10);
    check_scan("repress");

    // Maximum sum 3+3+1 = 7.
    set_in(2'b11, 2'b11, 1'b1, 2'b11, 1'b1);
    do_press(10, 10);
    check_scan("max");

    // Asynchronous reset mid-scan, between clock edges.
    step(5);
    @(negedge CLOCK);
    #2 RESETN = 1'b0;
    #1;
    check_eq("midrst_an", 32'(AN), 32'h0000000F);
    check_eq("midrst_seg", 32'(SEG), 32'h0000007F);
    check_eq("midrst_dp", 32'(DP), 32'd1);
    check_eq("midrst_captured", 32'(CAPTURED), 32'd0);
    check_eq("midrst_err", 32'(ERR), 32'd0);
    step(2);
    RESETN = 1'b1;
    step(1);
    check_blank("post_reset");
    check_eq("post_reset_captured", 32'(CAPTURED), 32'd0);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
